// File: rtl/fmc_cmd_pkg.sv
// Shared types and constants for the cmd-bus initiator (fmc_cmd_master).
package fmc_cmd_pkg;

  localparam int unsigned CMD_ADDR_BITS      = 32;
  localparam int unsigned CMD_DATA_BITS      = 32;
  localparam int unsigned TIMEOUT_CYCLES_MIN = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic                     rd_wr_n;
    logic [CMD_ADDR_BITS-1:0] addr;
    logic [CMD_DATA_BITS-1:0] wdata;
  } cmd_reg_t;

  // Keeps the watchdog limit usable even if a too-small value is configured.
  function automatic int unsigned timeout_clamp(input int unsigned cycles);
    return (cycles < TIMEOUT_CYCLES_MIN) ? TIMEOUT_CYCLES_MIN : cycles;
  endfunction

endpackage

// File: rtl/intf_cmd.sv
// cmd-bus: one-cycle sel strobe from the master, ack/rdata back from the slave.
interface intf_cmd;
  import fmc_cmd_pkg::*;

  logic                     sel;
  logic                     rd_wr_n;
  logic [CMD_ADDR_BITS-1:0] byte_addr;
  logic [CMD_DATA_BITS-1:0] wdata;
  logic                     ack;
  logic [CMD_DATA_BITS-1:0] rdata;

  modport master (output sel, rd_wr_n, byte_addr, wdata, input ack, rdata);
  modport slave  (input sel, rd_wr_n, byte_addr, wdata, output ack, rdata);
endinterface

// File: rtl/fmc_cmd_watchdog.sv
// Ack-timeout counter: cleared on issue, counts while enabled, saturates at LIMIT-1.
module fmc_cmd_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_BITS = $clog2(LIMIT);

  logic [CNT_BITS-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && !expired_c) begin
      cnt_q <= cnt_q + CNT_BITS'(1);
    end
  end

  assign expired_c = (cnt_q == CNT_BITS'(LIMIT - 1));

endmodule

// File: rtl/fmc_cmd_master.sv
// cmd-bus initiator: one outstanding request -> sel/ack transaction -> response.
// Optional ack watchdog compiled in with FMC_CMD_MASTER_TIMEOUT_EN.
module fmc_cmd_master
  import fmc_cmd_pkg::*;
#(
  parameter int unsigned DATA_BITS      = 32,
  parameter int unsigned ADDR_BITS      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_rd_wr_n,
  input  logic [ADDR_BITS-1:0] i_req_addr,
  input  logic [DATA_BITS-1:0] i_req_wdata,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [DATA_BITS-1:0] o_rsp_rdata,
  output logic                 o_rsp_err,
  intf_cmd.master              mem_cmd
);

  state_e               state_q, state_d;
  cmd_reg_t             cmd_q, cmd_d;
  logic                 ready_q, ready_d;
  logic                 sel_q, sel_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 expired_c;

`ifdef FMC_CMD_MASTER_TIMEOUT_EN
  fmc_cmd_watchdog #(
    .LIMIT (timeout_clamp(TIMEOUT_CYCLES))
  ) u_watchdog (
    .clk       (i_sys_clk),
    .rst       (i_sys_rst),
    .clr       (state_q == ST_ISSUE),
    .en        (state_q == ST_WAIT_ACK),
    .expired_c (expired_c)
  );

  assign o_rsp_err = err_q;
`else
  logic unused_cfg;

  assign expired_c  = 1'b0;
  assign o_rsp_err  = 1'b0;
  assign unused_cfg = ^{err_q, 32'(TIMEOUT_CYCLES)};
`endif

  // Next state plus next value of every registered output.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid && ready_q) begin
          cmd_d.rd_wr_n = i_req_rd_wr_n;
          cmd_d.addr    = CMD_ADDR_BITS'(i_req_addr);
          cmd_d.wdata   = CMD_DATA_BITS'(i_req_wdata);
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // rdata is only driven by the slave while it acks; ack beats expiry.
        if (mem_cmd.ack) begin
          rdata_d = cmd_q.rd_wr_n ? DATA_BITS'(mem_cmd.rdata) : '0;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (expired_c) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    sel_d   = (state_d == ST_ISSUE);
    valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '{rd_wr_n: 1'b1, addr: '0, wdata: '0};
      ready_q <= 1'b0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ready_q <= ready_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Command fields change only on accept, so they hold from sel through ack.
  assign mem_cmd.sel       = sel_q;
  assign mem_cmd.rd_wr_n   = cmd_q.rd_wr_n;
  assign mem_cmd.byte_addr = cmd_q.addr;
  assign mem_cmd.wdata     = cmd_q.wdata;

  assign o_req_ready = ready_q;
  assign o_rsp_valid = valid_q;
  assign o_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_fmc_cmd_master.sv
// Bench for fmc_cmd_master: slave memory model, per-cycle reference model, directed + random traffic.
module tb_fmc_cmd_master;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_rd;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  always #5 clk = ~clk;

  intf_cmd mem_if ();

  fmc_cmd_master #(
    .DATA_BITS      (DW),
    .ADDR_BITS      (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_sys_clk     (clk),
    .i_sys_rst     (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_rd_wr_n (req_rd),
    .i_req_addr    (req_addr),
    .i_req_wdata   (req_wdata),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_rdata   (rsp_rdata),
    .o_rsp_err     (rsp_err),
    .mem_cmd       (mem_if.master)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input int a);
    return 32'hC0DE_0000 + 32'(a) * 32'd7;
  endfunction

  // ---------------- slave memory: acks lat_cfg cycles after sel ----------------
  int          lat_cfg = 2;
  bit          no_ack  = 1'b0;
  int          s_cnt   = 0;
  logic        s_ack   = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        spur    = 1'b0;
  logic [31:0] s_mem [int];

  function automatic logic [31:0] slv_rd(input int a);
    return s_mem.exists(a) ? s_mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      s_cnt <= 0;
      s_ack <= 1'b0;
    end else begin
      s_ack <= 1'b0;
      if (mem_if.sel && !no_ack) begin
        if (lat_cfg <= 1) begin
          s_ack   <= 1'b1;
          s_rdata <= slv_rd(int'(mem_if.byte_addr));
        end else begin
          s_cnt <= lat_cfg - 1;
        end
      end else if (s_cnt > 0) begin
        s_cnt <= s_cnt - 1;
        if (s_cnt == 1) begin
          s_ack   <= 1'b1;
          s_rdata <= slv_rd(int'(mem_if.byte_addr));
        end
      end
    end
  end

  // Write commit samples the address in the ack cycle.
  always @(negedge clk) begin
    if (s_ack && !mem_if.rd_wr_n) s_mem[int'(mem_if.byte_addr)] = mem_if.wdata;
  end

  assign mem_if.ack   = s_ack | spur;
  assign mem_if.rdata = (s_ack | spur) ? s_rdata : 'z;

  // ---------------- reference model (transaction timestamps) ----------------
  logic        rst_last;
  bit          e_ready   = 1'b0;
  bit          e_valid   = 1'b0;
  bit          e_err     = 1'b0;
  logic [31:0] e_rdata   = '0;
  bit          in_flight = 1'b0;
  int          sel_cyc   = 0;
  bit          a_rd;
  logic [AW-1:0] a_addr;
  logic [31:0] a_wdata;
  logic [31:0] m_mem [int];
  int          sel_count = 0;
  int          rsp_count = 0;

  function automatic logic [31:0] mdl_rd(input int a);
    return m_mem.exists(a) ? m_mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_last <= rst;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("rdata_known", 64'($isunknown(rsp_rdata)), 64'(0));
      if (rst_last) begin
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_err",   64'(rsp_err),   64'(0));
        chk("rst_sel",   64'(mem_if.sel), 64'(0));
        chk("rst_rdwrn", 64'(mem_if.rd_wr_n), 64'(1));
        chk("rst_addr",  64'(mem_if.byte_addr), 64'(0));
        chk("rst_wdata", 64'(mem_if.wdata), 64'(0));
      end else begin
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("sel", 64'(mem_if.sel), 64'(in_flight && (cyc == sel_cyc)));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_valid));
        if (e_valid) begin
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
          chk("rsp_err",   64'(rsp_err),   64'(e_err));
        end
        if (in_flight) begin
          chk("bus_rdwrn", 64'(mem_if.rd_wr_n), 64'(a_rd));
          chk("bus_addr",  64'(mem_if.byte_addr), 64'(a_addr));
          chk("bus_wdata", 64'(mem_if.wdata), 64'(a_wdata));
        end
        if (rsp_valid) rsp_count++;
      end
      if (mem_if.sel) sel_count++;

      if (rst) begin
        in_flight = 1'b0;
        e_valid   = 1'b0;
        e_ready   = 1'b0;
      end else begin
        if (e_ready && req_valid) begin
          in_flight = 1'b1;
          sel_cyc   = cyc + 1;
          a_rd      = req_rd;
          a_addr    = req_addr;
          a_wdata   = req_wdata;
        end else if (in_flight && (cyc > sel_cyc)) begin
          if (mem_if.ack) begin
            e_valid = 1'b1;
            e_err   = 1'b0;
            if (a_rd) begin
              e_rdata = mdl_rd(int'(a_addr));
            end else begin
              e_rdata = '0;
              m_mem[int'(a_addr)] = a_wdata;
            end
            in_flight = 1'b0;
          end
`ifdef FMC_CMD_MASTER_TIMEOUT_EN
          else if ((cyc - sel_cyc) == int'(TO)) begin
            e_valid   = 1'b1;
            e_err     = 1'b1;
            e_rdata   = '0;
            in_flight = 1'b0;
          end
`endif
        end else if (e_valid && rsp_ready) begin
          e_valid = 1'b0;
        end
        e_ready = !in_flight && !e_valid;
      end
    end
  end

  // ---------------- background drivers for rsp_ready and spurious ack ----------------
  int rdy_mode = 0;
  bit spur_en  = 1'b0;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ($urandom_range(0, 2) != 0);
      default: rsp_ready = 1'b0;
    endcase
    spur = spur_en && ($urandom_range(0, 3) == 0) && !(in_flight && (cyc > sel_cyc));
  end

  // ---------------- request task ----------------
  int g_acc = 0;
  int g_hs  = 0;

  task automatic do_req(input bit rd, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input bit keep, input int hold,
                        output logic [31:0] rdata, output bit err, output int lat);
    bit ok;
    req_rd    = rd;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_bound", 64'(ok), 64'(1));
    g_acc = cyc;
    @(posedge clk);
    #1;
    if (keep) begin
      req_rd    = 1'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    if (hold > 0) rdy_mode = 2;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rsp_bound", 64'(ok), 64'(1));
    lat = cyc - g_acc;
    if (hold > 0) begin
      repeat (hold - 1) @(negedge clk);
      @(posedge clk);
      #1 rdy_mode = 0;
      @(negedge clk);
    end
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (rsp_valid && rsp_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("handshake_bound", 64'(ok), 64'(1));
    rdata = rsp_rdata;
    err   = rsp_err;
    g_hs  = cyc;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    bit          e;
    int          lat;
    int          base;
    int          prev_hs;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_rd    = 1'b1;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Write then read back through the slave memory.
    base = sel_count;
    do_req(1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 0, r, e, lat);
    chk("wr_rdata", 64'(r), 64'(0));
    chk("wr_err", 64'(e), 64'(0));
    chk("wr_latency", 64'(lat), 64'(4));
    do_req(1'b1, 12'h010, 32'h0, 1'b0, 0, r, e, lat);
    chk("rd_rdata", 64'(r), 64'(32'hDEADBEEF));
    chk("rd_err", 64'(e), 64'(0));
    chk("sel_pulses", 64'(sel_count - base), 64'(2));

    // Back-to-back with valid held high.
    for (int i = 0; i < 4; i++)
      do_req(1'b0, AW'(i), 32'h1111_0000 + 32'(i), 1'b1, 0, r, e, lat);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, AW'(i), 32'h0, 1'b1, 0, r, e, lat);
      chk("b2b_rdata", 64'(r), 64'(32'h1111_0000 + 32'(i)));
    end
    req_valid = 1'b0;

    // Response back-pressure, then immediate next request.
    do_req(1'b0, 12'h020, 32'h55AA55AA, 1'b0, 0, r, e, lat);
    do_req(1'b1, 12'h020, 32'h0, 1'b0, 10, r, e, lat);
    chk("hold_rdata", 64'(r), 64'(32'h55AA55AA));
    prev_hs = g_hs;
    do_req(1'b1, 12'h001, 32'h0, 1'b0, 0, r, e, lat);
    chk("next_accept", 64'(g_acc - prev_hs), 64'(1));
    chk("next_rdata", 64'(r), 64'(32'h1111_0001));

`ifdef FMC_CMD_MASTER_TIMEOUT_EN
    no_ack = 1'b1;
    do_req(1'b1, 12'h010, 32'h0, 1'b0, 0, r, e, lat);
    chk("to_err", 64'(e), 64'(1));
    chk("to_rdata", 64'(r), 64'(0));
    chk("to_latency", 64'(lat), 64'(TO + 2));
    no_ack  = 1'b0;
    lat_cfg = TO;
    do_req(1'b1, 12'h010, 32'h0, 1'b0, 0, r, e, lat);
    chk("expiry_ack_err", 64'(e), 64'(0));
    chk("expiry_ack_rdata", 64'(r), 64'(32'hDEADBEEF));
    lat_cfg = 2;
`endif

    // Reset two cycles after sel drops the transaction.
    lat_cfg   = 5;
    req_rd    = 1'b1;
    req_addr  = 12'h010;
    req_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    base = rsp_count;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    chk("rst_no_rsp", 64'(rsp_count - base), 64'(0));
    #1 lat_cfg = 2;
    do_req(1'b1, 12'h010, 32'h0, 1'b0, 0, r, e, lat);
    chk("post_rst_rdata", 64'(r), 64'(32'hDEADBEEF));

    // Spurious acks while idle.
    base = rsp_count;
    spur_en = 1'b1;
    repeat (20) @(posedge clk);
    #1 spur_en = 1'b0;
    repeat (3) @(posedge clk);
    chk("spur_no_rsp", 64'(rsp_count - base), 64'(0));
    #1;

    // Random traffic against the model.
    rdy_mode = 1;
    spur_en  = 1'b1;
    for (int i = 0; i < 150; i++) begin
      lat_cfg = $urandom_range(1, 5);
`ifdef FMC_CMD_MASTER_TIMEOUT_EN
      lat_cfg = $urandom_range(1, TO);
      no_ack  = ($urandom_range(0, 7) == 0);
`endif
      do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, 1'b1, 0, r, e, lat);
    end
    req_valid = 1'b0;
    spur_en   = 1'b0;
    no_ack    = 1'b0;
    rdy_mode  = 0;
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
